// File: rtl/sobel_pair_pipe.sv
// sobel_pair_pipe: three-stage Sobel gradient engine producing two edge
// pixels per 3x4 window. All stages advance together under a single
// valid/ready enable, so a stalled consumer freezes the whole pipeline.
module sobel_pair_pipe #(
    parameter int THRESH = 0,
    parameter int PIX_W  = 20
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [95:0]      in_window,
    input  logic [PIX_W-1:0] in_pixnum,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [15:0]      out_wdata,
    output logic [PIX_W-1:0] out_pixnum,
    input  logic             clr,
    output logic [PIX_W-1:0] pair_count,
    output logic             busy
);

    localparam logic [10:0] THR = 11'(THRESH);

    // Byte at row r, column c of the window.
    function automatic logic [7:0] px(input logic [95:0] w, input int r, input int c);
        return w[32*r+8*c +: 8];
    endfunction

    // 1-2-1 weighted sum of three bytes; at most 1020, fits 10 bits.
    function automatic logic [9:0] wsum(input logic [7:0] a, input logic [7:0] b,
                                        input logic [7:0] c);
        return 10'(a) + {1'b0, b, 1'b0} + 10'(c);
    endfunction

    logic                   adv;
    logic                   s1_valid;
    logic                   s2_valid;
    logic [PIX_W-1:0]       s1_pixnum;
    logic [PIX_W-1:0]       s2_pixnum;
    logic [1:0][9:0]        s1_l, s1_r, s1_t, s1_b;
    logic [1:0][9:0]        s1_l_d, s1_r_d, s1_t_d, s1_b_d;
    logic [1:0][9:0]        s2_ax, s2_ay;
    logic [1:0][9:0]        s2_ax_d, s2_ay_d;
    logic [15:0]            res_d;

    // The pipeline moves whenever the output slot is empty or being drained.
    assign adv      = ~out_valid | out_ready;
    assign in_ready = adv;
    assign busy     = s1_valid | s2_valid | out_valid;

    // Column and row sums for centres c=1 (k=0) and c=2 (k=1).
    always_comb begin
        for (int k = 0; k < 2; k++) begin
            s1_l_d[k] = wsum(px(in_window, 0, k),     px(in_window, 1, k),     px(in_window, 2, k));
            s1_r_d[k] = wsum(px(in_window, 0, k + 2), px(in_window, 1, k + 2), px(in_window, 2, k + 2));
            s1_t_d[k] = wsum(px(in_window, 0, k),     px(in_window, 0, k + 1), px(in_window, 0, k + 2));
            s1_b_d[k] = wsum(px(in_window, 2, k),     px(in_window, 2, k + 1), px(in_window, 2, k + 2));
        end
    end

    // Signed gradients and their magnitudes (|G| <= 1020 fits 10 bits).
    always_comb begin
        logic signed [10:0] gx;
        logic signed [10:0] gy;
        // NOTE: every combinational output gets a default before any
        // conditional assignment, so no path can leave it unassigned (latch).
        gx      = '0;
        gy      = '0;
        s2_ax_d = '0;
        s2_ay_d = '0;
        for (int k = 0; k < 2; k++) begin
            gx = signed'({1'b0, s1_r[k]}) - signed'({1'b0, s1_l[k]});
            gy = signed'({1'b0, s1_b[k]}) - signed'({1'b0, s1_t[k]});
            s2_ax_d[k] = gx[10] ? 10'(-gx) : gx[9:0];
            s2_ay_d[k] = gy[10] ? 10'(-gy) : gy[9:0];
        end
    end

    // Magnitude to output byte: saturate, or binarise against THRESH.
    always_comb begin
        logic [10:0] mag;
        mag   = '0;
        res_d = '0;
        for (int k = 0; k < 2; k++) begin
            mag = 11'(s2_ax[k]) + 11'(s2_ay[k]);
            if (THRESH != 0) begin
                res_d[8*k +: 8] = (mag >= THR) ? 8'hFF : 8'h00;
            end else begin
                res_d[8*k +: 8] = (mag > 11'd255) ? 8'hFF : mag[7:0];
            end
        end
    end

    // Valid bits and output registers: cleared by reset, shifted on adv.
    always_ff @(posedge clk or negedge n_rst) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // stage samples the pre-edge value of the stage before it.
        if (!n_rst) begin
            s1_valid   <= 1'b0;
            s2_valid   <= 1'b0;
            out_valid  <= 1'b0;
            out_wdata  <= '0;
            out_pixnum <= '0;
        end else if (adv) begin
            s1_valid  <= in_valid;
            s2_valid  <= s1_valid;
            out_valid <= s2_valid;
            if (s2_valid) begin
                out_wdata  <= res_d;
                out_pixnum <= s2_pixnum;
            end
        end
    end

    // Intermediate datapath registers, qualified only by their valid bits.
    always_ff @(posedge clk) begin
        // NOTE: these carry no reset; nothing downstream uses them unless the
        // matching valid bit is set, and that bit is reset.
        if (adv) begin
            s1_l      <= s1_l_d;
            s1_r      <= s1_r_d;
            s1_t      <= s1_t_d;
            s1_b      <= s1_b_d;
            s1_pixnum <= in_pixnum;
            s2_ax     <= s2_ax_d;
            s2_ay     <= s2_ay_d;
            s2_pixnum <= s1_pixnum;
        end
    end

    // Consumed-result counter; clr takes priority over a transfer.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            pair_count <= '0;
        end else if (clr) begin
            pair_count <= '0;
        end else if (out_valid && out_ready) begin
            pair_count <= pair_count + PIX_W'(1);
        end
    end

endmodule

// File: tb/tb_sobel_pair_pipe.sv
// Bench for sobel_pair_pipe: four instances (raw, THRESH=50, THRESH=40,
// 3-bit tag/count) share one stimulus stream and are checked against a
// kernel-convolution reference model and an in-order scoreboard.
module tb_sobel_pair_pipe;

    localparam int PW = 20;

    logic          tb_clk = 1'b0;
    logic          n_rst;
    logic          in_valid;
    logic          out_ready;
    logic          clr;
    logic [95:0]   in_window;
    logic [PW-1:0] in_pixnum;

    logic          in_ready, out_valid, busy;
    logic [15:0]   out_wdata;
    logic [PW-1:0] out_pixnum, pair_count;

    logic          t50_in_ready, t50_out_valid, t50_busy;
    logic [15:0]   t50_out_wdata;
    logic [PW-1:0] t50_out_pixnum, t50_pair_count;

    logic          t40_in_ready, t40_out_valid, t40_busy;
    logic [15:0]   t40_out_wdata;
    logic [PW-1:0] t40_out_pixnum, t40_pair_count;

    logic          w3_in_ready, w3_out_valid, w3_busy;
    logic [15:0]   w3_out_wdata;
    logic [2:0]    w3_out_pixnum, w3_pair_count;

    always #5 tb_clk = ~tb_clk;

    sobel_pair_pipe #(.THRESH(0), .PIX_W(PW)) dut (
        .clk(tb_clk), .n_rst(n_rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_window(in_window), .in_pixnum(in_pixnum), .out_valid(out_valid),
        .out_ready(out_ready), .out_wdata(out_wdata), .out_pixnum(out_pixnum),
        .clr(clr), .pair_count(pair_count), .busy(busy)
    );

    sobel_pair_pipe #(.THRESH(50), .PIX_W(PW)) dut_t50 (
        .clk(tb_clk), .n_rst(n_rst), .in_valid(in_valid), .in_ready(t50_in_ready),
        .in_window(in_window), .in_pixnum(in_pixnum), .out_valid(t50_out_valid),
        .out_ready(out_ready), .out_wdata(t50_out_wdata), .out_pixnum(t50_out_pixnum),
        .clr(clr), .pair_count(t50_pair_count), .busy(t50_busy)
    );

    sobel_pair_pipe #(.THRESH(40), .PIX_W(PW)) dut_t40 (
        .clk(tb_clk), .n_rst(n_rst), .in_valid(in_valid), .in_ready(t40_in_ready),
        .in_window(in_window), .in_pixnum(in_pixnum), .out_valid(t40_out_valid),
        .out_ready(out_ready), .out_wdata(t40_out_wdata), .out_pixnum(t40_out_pixnum),
        .clr(clr), .pair_count(t40_pair_count), .busy(t40_busy)
    );

    sobel_pair_pipe #(.THRESH(0), .PIX_W(3)) dut_w3 (
        .clk(tb_clk), .n_rst(n_rst), .in_valid(in_valid), .in_ready(w3_in_ready),
        .in_window(in_window), .in_pixnum(in_pixnum[2:0]), .out_valid(w3_out_valid),
        .out_ready(out_ready), .out_wdata(w3_out_wdata), .out_pixnum(w3_out_pixnum),
        .clr(clr), .pair_count(w3_pair_count), .busy(w3_busy)
    );

    typedef struct {
        logic [95:0]   win;
        logic [PW-1:0] tag;
    } item_t;

    item_t         sb[$];
    int            compared   = 0;
    int            mismatched = 0;
    logic [PW-1:0] model_cnt  = '0;
    bit            stalled_prev = 1'b0;
    logic [15:0]   prev_wdata;
    logic [PW-1:0] prev_pixnum;

    // Gradient magnitude |Gx|+|Gy| at centre (1,cc) by direct 3x3 convolution.
    function automatic int sobel_mag(input logic [95:0] w, input int cc);
        int gx = 0;
        int gy = 0;
        int p;
        for (int r = 0; r < 3; r++) begin
            for (int d = -1; d <= 1; d++) begin
                p  = int'(w[32*r + 8*(cc+d) +: 8]);
                gx += d * (2 - ((r == 1) ? 0 : 1)) * p;
                gy += (r - 1) * (2 - ((d == 0) ? 0 : 1)) * p;
            end
        end
        if (gx < 0) gx = -gx;
        if (gy < 0) gy = -gy;
        return gx + gy;
    endfunction

    function automatic logic [7:0] to_byte(input int mag, input int thr);
        if (thr == 0) return (mag > 255) ? 8'hFF : 8'(mag);
        return (mag >= thr) ? 8'hFF : 8'h00;
    endfunction

    function automatic logic [15:0] expect16(input logic [95:0] w, input int thr);
        return {to_byte(sobel_mag(w, 2), thr), to_byte(sobel_mag(w, 1), thr)};
    endfunction

    function automatic logic [95:0] rand_window();
        logic [95:0] w;
        for (int i = 0; i < 3; i++) w[32*i +: 32] = $urandom;
        return w;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: inspect outputs at the falling edge, update the model,
    // then advance past the rising edge and compare the counters.
    task automatic tick(output bit acc);
        item_t it;
        bit    consume;
        @(negedge tb_clk);
        check("in_ready_rule", in_ready, !out_valid || out_ready);
        if (stalled_prev) begin
            check("hold_valid", out_valid, 1);
            check("hold_wdata", out_wdata, prev_wdata);
            check("hold_pixnum", out_pixnum, prev_pixnum);
        end
        consume = out_valid && out_ready;
        if (consume) begin
            if (sb.size() == 0) begin
                check("spurious_out", out_valid, 0);
            end else begin
                it = sb.pop_front();
                check("wdata_raw", out_wdata, expect16(it.win, 0));
                check("wdata_t50", t50_out_wdata, expect16(it.win, 50));
                check("wdata_t40", t40_out_wdata, expect16(it.win, 40));
                check("wdata_w3", w3_out_wdata, expect16(it.win, 0));
                check("pixnum", out_pixnum, it.tag);
                check("pixnum_w3", w3_out_pixnum, it.tag[2:0]);
            end
        end
        acc = in_valid && in_ready;
        if (acc) begin
            it.win = in_window;
            it.tag = in_pixnum;
            sb.push_back(it);
        end
        stalled_prev = out_valid && !out_ready;
        prev_wdata   = out_wdata;
        prev_pixnum  = out_pixnum;
        if (clr) model_cnt = '0;
        else if (consume) model_cnt = model_cnt + 1'b1;
        @(posedge tb_clk);
        #1;
        check("pair_count", pair_count, model_cnt);
        check("pair_count_w3", w3_pair_count, model_cnt[2:0]);
    endtask

    task automatic send(input logic [95:0] w, input logic [PW-1:0] t);
        bit acc = 1'b0;
        in_valid  = 1'b1;
        in_window = w;
        in_pixnum = t;
        for (int i = 0; i < 20 && !acc; i++) tick(acc);
        in_valid = 1'b0;
        check("send_accepted", acc, 1);
    endtask

    task automatic drain();
        bit acc;
        for (int i = 0; i < 40 && (sb.size() != 0 || busy); i++) tick(acc);
        check("drain_empty", sb.size(), 0);
    endtask

    task automatic wait_out();
        bit acc;
        for (int i = 0; i < 10 && !out_valid; i++) tick(acc);
        check("out_valid_seen", out_valid, 1);
    endtask

    task automatic send_expect(input logic [95:0] w, input logic [PW-1:0] t,
                               input logic [15:0] e0, input logic [15:0] e50,
                               input logic [15:0] e40);
        send(w, t);
        wait_out();
        check("directed_raw", out_wdata, e0);
        check("directed_t50", t50_out_wdata, e50);
        check("directed_t40", t40_out_wdata, e40);
        check("directed_tag", out_pixnum, t);
        drain();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit            acc;
        logic [95:0]   flat_w, vert_w, ramp_w;
        logic [95:0]   stream_w[6];
        int            sent, stall;
        bit            seen;

        n_rst     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        clr       = 1'b0;
        in_window = '0;
        in_pixnum = '0;

        // Reset state.
        #12;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_wdata", out_wdata, 0);
        check("rst_out_pixnum", out_pixnum, 0);
        check("rst_pair_count", pair_count, 0);
        check("rst_busy", busy, 0);
        n_rst = 1'b1;
        @(posedge tb_clk);
        #1;
        check("rst_in_ready", in_ready, 1);

        // Flat window: latency of three cycles, zero gradient.
        for (int i = 0; i < 12; i++) flat_w[8*i +: 8] = 8'd100;
        send(flat_w, 7);
        check("lat_busy", busy, 1);
        check("lat_valid_1", out_valid, 0);
        tick(acc);
        check("lat_valid_2", out_valid, 0);
        tick(acc);
        check("lat_valid_3", out_valid, 1);
        check("flat_raw", out_wdata, 16'h0000);
        check("flat_t40", t40_out_wdata, 16'h0000);
        check("flat_tag", out_pixnum, 7);
        drain();

        // Vertical edge: |Gx| = 1020 saturates both pixels.
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 4; c++)
                vert_w[32*r + 8*c +: 8] = (c >= 2) ? 8'd255 : 8'd0;
        send_expect(vert_w, 11, 16'hFFFF, 16'hFFFF, 16'hFFFF);

        // Horizontal ramp: |Gy| = 40, exercises both threshold sides.
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 4; c++)
                ramp_w[32*r + 8*c +: 8] = (r == 2) ? 8'd20 : 8'd10;
        send_expect(ramp_w, 12, 16'h2828, 16'h0000, 16'hFFFF);

        // clr coincident with a consumed result while the count is 3.
        check("pre_clr_count", pair_count, 3);
        send(rand_window(), 13);
        wait_out();
        clr = 1'b1;
        tick(acc);
        clr = 1'b0;
        check("clr_wins", pair_count, 0);
        drain();

        // Six back-to-back windows with a five-cycle output stall.
        for (int i = 0; i < 6; i++) stream_w[i] = rand_window();
        sent  = 0;
        stall = 0;
        seen  = 1'b0;
        for (int cyc = 0; cyc < 80 && !(sent == 6 && sb.size() == 0); cyc++) begin
            in_valid = (sent < 6);
            if (sent < 6) begin
                in_window = stream_w[sent];
                in_pixnum = PW'(100 + sent);
            end
            if (seen && stall < 5) begin
                out_ready = 1'b0;
                stall++;
                #1;
                check("stall_in_ready", in_ready, 0);
            end else begin
                out_ready = 1'b1;
            end
            tick(acc);
            if (acc) sent++;
            if (out_valid) seen = 1'b1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check("stream_sent", sent, 6);
        check("stream_done", sb.size(), 0);
        check("stream_count", pair_count, 6);
        drain();

        // Random traffic with random backpressure and occasional clr;
        // the 3-bit counter wraps repeatedly here.
        for (int i = 0; i < 150; i++) begin
            in_valid  = ($urandom_range(0, 2) != 0);
            in_window = rand_window();
            in_pixnum = PW'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            clr       = ($urandom_range(0, 24) == 0);
            tick(acc);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        clr       = 1'b0;
        drain();

        // Asynchronous reset with two windows in flight.
        in_valid  = 1'b1;
        in_window = rand_window();
        in_pixnum = 20'h00AAA;
        tick(acc);
        in_window = rand_window();
        in_pixnum = 20'h00BBB;
        tick(acc);
        in_valid = 1'b0;
        check("mid_busy", busy, 1);
        #2;
        n_rst = 1'b0;
        #1;
        check("arst_out_valid", out_valid, 0);
        check("arst_busy", busy, 0);
        check("arst_pair_count", pair_count, 0);
        sb.delete();
        model_cnt    = '0;
        stalled_prev = 1'b0;
        #2;
        n_rst = 1'b1;
        for (int i = 0; i < 8; i++) tick(acc);
        check("post_rst_valid", out_valid, 0);
        check("post_rst_busy", busy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/sobel_pair_pipe.md
Name: sobel_pair_pipe

Overview:
Pipelined Sobel gradient engine between the sample image storage and the edge-detection write path. Accepts one 3-row x 4-column 8-bit pixel window per transfer and produces two edge-magnitude pixels packed in 16 bits, in the same byte order the write path uses. Fixed 3-cycle latency, valid/ready handshake on both sides with full backpressure, and a pixel-number tag carried alongside the data.

Parameters:
THRESH, 0, binarisation threshold; 0 = raw saturated magnitude, 1..255 = output 8'hFF if magnitude >= THRESH else 8'h00
PIX_W, 20, width of the pixel-number tag

Ports:
clk  in  1  system clock
n_rst  in  1  asynchronous active-low reset
in_valid  in  1  window present on in_window/in_pixnum
in_ready  out  1  block accepts window this cycle
in_window  in  96  p[r][c] = in_window[32*r+8*c +: 8], r=0..2 (top..bottom), c=0..3 (left..right)
in_pixnum  in  PIX_W  output pixel index of the left result pixel, passed through unchanged
out_valid  out  1  result present
out_ready  in  1  consumer accepts result this cycle
out_wdata  out  16  [7:0] = pixel centred on (r1,c1); [15:8] = pixel centred on (r1,c2)
out_pixnum  out  PIX_W  tag of the result
clr  in  1  synchronous clear of pair_count
pair_count  out  PIX_W  number of results consumed (out_valid & out_ready), wraps at 2^PIX_W
busy  out  1  OR of all stage valid bits

Behaviour:
- Reset: all stage valid bits 0, out_valid=0, out_wdata=0, out_pixnum=0, pair_count=0, busy=0; in_ready=1 once reset is released. Asserting reset mid-operation discards all in-flight windows.
- Advance enable: adv = ~out_valid | out_ready. in_ready = adv (combinational). All three stages shift together when adv=1 and hold otherwise. There are no bubbles to collapse.
- Transfer in: occurs when in_valid & in_ready. Stage-1 valid loads in_valid when adv=1.
- Stage 1: for each output centre c in {1,2}, register the column sums L = p0[c-1]+2*p1[c-1]+p2[c-1] and R = p0[c+1]+2*p1[c+1]+p2[c+1], and the row sums T = p0[c-1]+2*p0[c]+p0[c+1] and B = p2[c-1]+2*p2[c]+p2[c+1]. Each sum is 10 bits unsigned, range 0..1020.
- Stage 2: Gx = R-L and Gy = B-T as 11-bit signed; register |Gx| and |Gy| as 10-bit unsigned values.
- Stage 3: mag = |Gx|+|Gy| (11 bits, 0..2040). Output = 255 if mag>255, else mag[7:0]. If THRESH!=0, output = (mag>=THRESH) ? 8'hFF : 8'h00, where the comparison uses the unsaturated mag. The result registers into out_wdata and out_valid.
- Latency: a window accepted at edge N gives out_valid=1 after edge N+3 when out_ready is held at 1. Throughput is 1 window per cycle.
- Backpressure: while out_valid=1 and out_ready=0, out_wdata, out_pixnum and all stage contents stay stable and in_ready=0. No data is lost or duplicated.
- Tag: in_pixnum travels through the pipeline with its window. out_pixnum always corresponds to out_wdata.
- pair_count: increments on out_valid & out_ready. If clr and a transfer occur in the same cycle, clr wins and the count becomes 0.
- Invalid stages: data registers may update freely, but out_wdata changes only when a valid result loads.

Test Plan:
- Flat window (every byte 100), in_pixnum=7 -> 3 cycles later out_valid=1, out_wdata=16'h0000, out_pixnum=7.
- Vertical edge (columns 0,1 = 0; columns 2,3 = 255 on all rows) -> Gx=1020 for both centres, so out_wdata=16'hFFFF (saturated).
- Horizontal ramp (row0=row1=10, row2=20 on all columns) -> Gy=40, Gx=0, so out_wdata=16'h2828. The same input with THRESH=50 gives 16'h0000; with THRESH=40 it gives 16'hFFFF.
- Streaming with backpressure: send 6 windows back-to-back, hold out_ready=0 for 5 cycles after the first result -> in_ready=0 during the stall, all 6 results arrive in order with correct tags, and pair_count=6 at the end.
- Reset mid-stream: 2 windows in flight, pulse n_rst low asynchronously between clock edges -> out_valid and busy go to 0 at once, no stale result appears after release, and pair_count=0.
- clr coincident with a consumed transfer when pair_count=3 -> pair_count=0 on the next cycle. pair_count at 2^PIX_W-1 with one transfer -> wraps to 0.
